// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern generator and the detector benches.
//   - seq_state_t : 2-bit generator state encoding
//   - PAT_10101   : default pattern shared with the detector benches
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ENC_SEND = 2'd1;
    localparam logic [STATE_W-1:0] ENC_GAP  = 2'd2;
    localparam logic [STATE_W-1:0] ENC_DONE = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = ENC_IDLE,
        ST_SEND = ENC_SEND,
        ST_GAP  = ENC_GAP,
        ST_DONE = ENC_DONE
    } seq_state_t;

    localparam logic [4:0] PAT_10101 = 5'b10101;

endpackage

// File: rtl/seq_piso_shift.sv
// ----------------------------------------------------------------------------
// seq_piso_shift
// PAT_W-bit parallel-load, MSB-first shift register. Load has priority over
// shift; each shift moves the register one place towards the MSB, filling 0.
// Ports:
//   clk, rstn   : clock, async active-low reset (clears the register)
//   load        : load load_val on the next rising edge
//   shift       : shift left by one on the next rising edge
//   load_val    : parallel load value
//   msb         : current MSB (bit on the line now)
//   msb_nxt     : bit that becomes the MSB after one shift
// ----------------------------------------------------------------------------
module seq_piso_shift #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             msb_nxt
);

    logic [PAT_W-1:0] data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_val;
        end else if (shift) begin
            data_q <= {data_q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb     = data_q[PAT_W-1];
    assign msb_nxt = data_q[PAT_W-2];

endmodule

// File: rtl/seq_pattern_gen.sv
// ----------------------------------------------------------------------------
// seq_pattern_gen
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// rep+1 times, with GAP idle cycles between frames, then pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start (abort low); all outputs low
// SEND    | pattern bit on out, valid=1
// GAP     | idle cycles between frames, out=0, valid=0
// DONE    | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rstn : clock, async active-low reset
//   start     : send request, sampled only in IDLE
//   abort     : synchronous abort, returns to IDLE from any state
//   pat_in    : pattern, latched on start accept
//   rep       : frame count minus one, latched on start accept
//   out       : serial data (registered)
//   valid     : out carries a pattern bit
//   busy      : transfer in progress
//   done      : one-cycle pulse after the last bit of the last frame
// ----------------------------------------------------------------------------
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int GAP   = 0,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int              BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    seq_state_t       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    logic             sh_load, sh_shift;
    logic [PAT_W-1:0] sh_load_val;
    logic             sh_msb, sh_msb_nxt;
    logic             line_bit_d;
    logic             out_d, valid_d, busy_d, done_d;

    seq_piso_shift #(.PAT_W(PAT_W)) u_shift (
        .clk      (clk),
        .rstn     (rstn),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (sh_load_val),
        .msb      (sh_msb),
        .msb_nxt  (sh_msb_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            out         <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            out         <= out_d;
            valid       <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_load_val = pat_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_SEND;
                    pat_d       = pat_in;
                    frame_cnt_d = rep;
                    bit_cnt_d   = '0;
                    sh_load     = 1'b1;
                    sh_load_val = pat_in;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == BIT_LAST) begin
                    if (frame_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LAST;
                    end else begin
                        // back-to-back frame: reload without a bubble
                        sh_load     = 1'b1;
                        frame_cnt_d = frame_cnt_q - REP_W'(1);
                        bit_cnt_d   = '0;
                    end
                end else begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == 4'd0) begin
                    state_d     = ST_SEND;
                    sh_load     = 1'b1;
                    frame_cnt_d = frame_cnt_q - REP_W'(1);
                    bit_cnt_d   = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so out must be the bit the
    // shift register will present after this edge.
    always_comb begin
        line_bit_d = sh_msb;
        if (sh_load) begin
            line_bit_d = sh_load_val[PAT_W-1];
        end else if (sh_shift) begin
            line_bit_d = sh_msb_nxt;
        end
        valid_d = (state_d == ST_SEND);
        out_d   = valid_d & line_bit_d;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_gen
// Directed bench for seq_pattern_gen. Two instances: GAP=0 and GAP=3.
// Outputs are sampled on the falling edge and packed as {out,valid,busy,done}.
// ----------------------------------------------------------------------------
module tb_seq_pattern_gen;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_0 = 1'b0;
    logic       start_1 = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] pat_in = '0;
    logic [3:0] rep = '0;

    logic out_0, valid_0, busy_0, done_0;
    logic out_1, valid_1, busy_1, done_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(5), .GAP(0), .REP_W(4)) dut_g0 (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start_0),
        .abort  (abort),
        .pat_in (pat_in),
        .rep    (rep),
        .out    (out_0),
        .valid  (valid_0),
        .busy   (busy_0),
        .done   (done_0)
    );

    seq_pattern_gen #(.PAT_W(5), .GAP(3), .REP_W(4)) dut_g3 (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start_1),
        .abort  (abort),
        .pat_in (pat_in),
        .rep    (rep),
        .out    (out_1),
        .valid  (valid_1),
        .busy   (busy_1),
        .done   (done_1)
    );

    function automatic logic [3:0] obs(input int sel);
        return (sel != 0) ? {out_1, valid_1, busy_1, done_1}
                          : {out_0, valid_0, busy_0, done_0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends one transfer and checks every cycle against frame arithmetic:
    // period = 5 bits + gap idle cycles, last period has no gap, then done,
    // then idle. A 10101 detector runs on the observed line.
    task automatic run_frames(input string tag, input int sel, input logic [4:0] pat,
                              input int nrep, input int gap, input int det_exp,
                              input int mid_start);
        int         total;
        int         idx;
        int         pos;
        int         hits;
        logic [4:0] hist;
        logic [3:0] e;
        logic [3:0] o;
        total = (nrep + 1) * 5 + nrep * gap;
        hits  = 0;
        hist  = '0;
        @(negedge clk);
        pat_in = pat;
        rep    = 4'(nrep);
        if (sel != 0) start_1 = 1'b1; else start_0 = 1'b1;
        @(negedge clk);
        start_0 = 1'b0;
        start_1 = 1'b0;
        for (int k = 1; k <= total + 2; k++) begin
            idx = k - 1;
            if (idx < total) begin
                pos = idx % (5 + gap);
                if (pos < 5) e = {pat[4 - pos], 3'b110};
                else         e = 4'b0010;
            end else if (idx == total) begin
                e = 4'b0011;
            end else begin
                e = 4'b0000;
            end
            o = obs(sel);
            chk($sformatf("%s cyc%0d", tag, k), {28'd0, o}, {28'd0, e});
            hist = {hist[3:0], o[3]};
            if (hist == PAT_10101) hits++;
            if (k == mid_start) begin
                if (sel != 0) start_1 = 1'b1; else start_0 = 1'b1;
                pat_in = ~pat;
                rep    = 4'd9;
            end else begin
                start_0 = 1'b0;
                start_1 = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " det"}, 32'(hits), 32'(det_exp));
    endtask

    initial begin
        logic [3:0] o;
        int         k;

        // reset and idle
        #12;
        chk("reset idle", {28'd0, obs(0)}, 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle0 %0d", i), {28'd0, obs(0)}, 32'd0);
            chk($sformatf("idle1 %0d", i), {28'd0, obs(1)}, 32'd0);
        end

        // single frame 10101, then back-to-back two frames
        run_frames("one", 0, PAT_10101, 0, 0, 1, 0);
        run_frames("two", 0, PAT_10101, 1, 0, 2, 0);

        // 11001 x3 with 3-cycle gaps, start re-pulsed mid-run with other data
        run_frames("gap", 1, 5'b11001, 2, 3, 0, 8);

        // abort on the 3rd bit of frame 2 (cycle 8)
        @(negedge clk);
        pat_in  = PAT_10101;
        rep     = 4'd3;
        start_0 = 1'b1;
        @(negedge clk);
        start_0 = 1'b0;
        for (k = 1; k < 8; k++) @(negedge clk);
        chk("abort pre", {28'd0, obs(0)}, 32'b1110);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort idle", {28'd0, obs(0)}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort nodone %0d", i), {28'd0, obs(0)}, 32'd0);
        end
        run_frames("fresh", 0, 5'b01110, 0, 0, 0, 0);

        // asynchronous reset mid-frame
        @(negedge clk);
        pat_in  = 5'b11111;
        rep     = 4'd0;
        start_0 = 1'b1;
        @(negedge clk);
        start_0 = 1'b0;
        @(negedge clk);
        chk("pre rst", {28'd0, obs(0)}, 32'b1110);
        #2;
        rstn = 1'b0;
        #1;
        chk("async rst", {28'd0, obs(0)}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post rst %0d", i), {28'd0, obs(0)}, 32'd0);
        end

        // start with abort in IDLE is refused
        start_0 = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start_0 = 1'b0;
        abort   = 1'b0;
        chk("start+abort", {28'd0, obs(0)}, 32'd0);
        @(negedge clk);
        o = obs(0);
        chk("start+abort 2", {28'd0, o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter; the transmit-side counterpart of the team's serial sequence detectors.
- On a start request it loads a PAT_W-bit pattern and emits it MSB-first on a one-bit line, one bit per clock.
- It repeats the frame a programmable number of times, with optional idle gaps between frames.
- It drives the detector FSMs in system tests and in lab demos.

Parameters:
- PAT_W, 5, pattern length in bits (2..16).
- GAP, 0, number of idle cycles (out=0) inserted between consecutive frames (0..15).
- REP_W, 4, width of the repeat-count input.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  request to send; sampled only in IDLE.
- abort  input  1  synchronous abort; sampled in every state.
- pat_in  input  PAT_W  pattern; latched on the start-accept edge.
- rep  input  REP_W  frame count minus one; latched on the start-accept edge.
- out  output  1  serial data, registered.
- valid  output  1  high while out carries a pattern bit; low during gap, done and idle.
- busy  output  1  high from the start-accept edge until the return to IDLE.
- done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; out=0, valid=0, busy=0, done=0; shift register, bit counter, frame counter and gap counter all cleared.
- All outputs are registered (Moore). Clock and reset behaviour follow the team-wide decision: one clock; reset is asynchronous and active-low.
- States:
  - IDLE: out=0, valid=0, busy=0. If start=1 and abort=0: latch pat_in and rep, go to SEND, bit_cnt=0, frame_cnt=rep.
  - SEND: out=shift[PAT_W-1], valid=1, busy=1. Shift left each cycle.
    - When bit_cnt=PAT_W-1 and frame_cnt=0: go to DONE.
    - When bit_cnt=PAT_W-1, frame_cnt>0 and GAP>0: go to GAP.
    - When bit_cnt=PAT_W-1, frame_cnt>0 and GAP=0: reload the latched pattern, decrement frame_cnt, and stay in SEND. The next frame starts back-to-back with no bubble.
  - GAP: out=0, valid=0, busy=1, for exactly GAP cycles. Then reload the pattern, decrement frame_cnt, and go to SEND.
  - DONE: out=0, valid=0, busy=1, done=1 for one cycle. Then go to IDLE.
- Latency: if start is accepted at edge E, the first pattern bit is visible on out after E. The last bit of the last frame is visible after edge E+(rep+1)·PAT_W+rep·GAP−1. done is high in the following cycle.
- Frame count is rep+1: rep=0 sends one frame; rep=2^REP_W−1 sends 2^REP_W frames. No overflow.
- start while busy is ignored; it is not queued. pat_in and rep changes while busy have no effect, because they are latched.
- abort=1 in any non-IDLE state: the next state is IDLE, out=0, valid=0, busy=0. No done pulse.
- abort and start both high in IDLE: abort wins and the block stays IDLE.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). After release the block is in IDLE and needs a new start.
- Unused state encodings: next state is IDLE and outputs are 0.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding localparams (IDLE, SEND, GAP, DONE), 2-bit state width;
  - the default pattern constant PAT_10101=5'b10101, shared with the detector benches.
- One natural sub-module: seq_piso_shift, a PAT_W-bit parallel-load, MSB-first shift register with load/shift enables.
- The counters and the FSM stay in the top module.

Test Plan:
- Reset then idle, start=0 for 10 cycles -> out=0, valid=0, busy=0, done=0 throughout.
- pat_in=5'b10101, rep=0, GAP=0, start for one cycle -> out=1,0,1,0,1 on the 5 cycles after acceptance, valid=1 for exactly 5 cycles, done pulse on the 6th cycle, busy low on the 7th. A detector FSM for pattern 10101 fed from out fires exactly once.
- pat_in=5'b10101, rep=1, GAP=0 -> stream 1010110101 with no bubble (10 valid cycles), single done. The detector fires twice.
- pat_in=5'b11001, rep=2, GAP=3 -> 11001,000,11001,000,11001 (valid low during each gap), done after 21 cycles. start pulsed mid-run is ignored.
- pat_in=5'b10101, rep=3, abort raised on the 3rd bit of frame 2 -> IDLE next cycle, out=0, busy=0, no done pulse. A fresh start then transmits normally.
- rstn pulled low mid-frame (between edges) -> out, valid and busy drop immediately. After release with start=0, the block stays idle. A start with abort=1 in IDLE is not accepted.
